ad5681r_dac_spi: RTL
====================

# ad5681r_dac_spi

Serial driver for the on-board 12-bit AD5681R DAC. It accepts one command/code word per handshake from fabric logic and emits the 24-bit SPI frame directly onto the AD5681R_* board pins. It also owns the DAC hardware reset (RSTn) and load (LDACn) strobes. It sits between the control logic (Nios II PIO or a sample generator) and the top-level DAC pins.

## Interface
- CLK_DIV, 2: SYS_CLK cycles per SCL half-period; legal range ≥1. The default gives 12.5 MHz SCL from 50 MHz.
- RST_CYCLES, 50: SYS_CLK cycles that AD5681R_RSTn is held low after reset (1 µs at 50 MHz); legal range ≥1.
- SYS_CLK  in  1  50 MHz system clock; the only clock.
- RESET  in  1  reset, synchronous, active-high.
- cmd  in  4  AD5681R command nibble (frame bits 23:20).
- code  in  12  DAC code (frame bits 19:8).
- valid  in  1  request; cmd and code are sampled when valid && ready.
- ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transaction fully completes.
- AD5681R_SYNCn  out  1  frame select, active low.
- AD5681R_SCL  out  1  serial clock, idles high.
- AD5681R_SDA  out  1  serial data, MSB first.
- AD5681R_LDACn  out  1  load strobe, active low.
- AD5681R_RSTn  out  1  DAC reset, active low.

## Operation
- Frame word = {cmd, code, 8'h00}: 24 bits, shifted MSB first. The DAC samples SDA on falling SCL edges. SDA changes only while SCL is high or while SYNCn is high.
- All outputs are registered with no combinational path from input to pin.
- States and transitions:
  - RST_HOLD: RSTn=0 and a counter runs; after RST_CYCLES cycles, RSTn=1 and the block moves to IDLE.
  - IDLE: ready=1. On valid, latch the frame into the shift register and move to SETUP.
  - SETUP: SYNCn=0, SDA=bit 23, SCL=1 for CLK_DIV cycles, then move to SHIFT.
  - SHIFT: 24 bit periods. Each period is SCL=0 for CLK_DIV cycles, then SCL=1 for CLK_DIV cycles. On each rising SCL, present the next bit. The bit counter runs 23→0. After the 24th high phase, move to HOLD.
  - HOLD: SYNCn=1, SCL=1, SDA=0. After CLK_DIV cycles:
    - if the latched cmd == 4'b0001 (write input register), move to LDAC;
    - otherwise move to GAP.
  - LDAC: LDACn=0 for CLK_DIV cycles, then move to GAP.
  - GAP: SYNCn held high for CLK_DIV cycles; done=1 on the last cycle; then move to IDLE.
- valid while busy is ignored. The request is not queued; the requester must hold valid until ready.
- Any cmd value is passed through unmodified; only 4'b0001 adds the LDAC pulse.
- RESET has priority in every state, mid-frame included. The next edge forces the reset values and enters RST_HOLD. A partial frame is abandoned; the DAC is re-reset by RSTn.

## Timing
- Reset values: SYNCn=1, SCL=1, SDA=0, LDACn=1, RSTn=0, ready=0, busy=1, done=0. The shift register and all counters clear to 0.
- RESET deasserted at edge 0: RSTn rises and ready rises on edge RST_CYCLES.
- Acceptance: valid && ready at edge N gives SYNCn=0 from edge N+1.
- First SCL fall occurs at N+1+CLK_DIV.
- SYNCn rises at N+1+CLK_DIV+48·CLK_DIV.
- Total busy length:
  - without LDAC: 51·CLK_DIV cycles (102 at the default); done in the last busy cycle; ready returns the following cycle;
  - with cmd 0001: 52·CLK_DIV cycles (104 at the default).
- Back-to-back transfers: SYNCn high time ≥ 2·CLK_DIV cycles between frames.
- Exactly 24 SCL falling edges occur per SYNCn low window. SCL is high at both the falling and rising edges of SYNCn.

## Test plan
- Reset release with RST_CYCLES=50: RSTn low for exactly 50 cycles; ready rises on the cycle RSTn rises; SYNCn/SCL stay high and LDACn stays high throughout.
- cmd=4'h3, code=12'hABC, CLK_DIV=2: the bench samples SDA on 24 SCL falls and gets 24'h3ABC00. SYNCn low for 98 cycles. busy length 102 cycles. One done pulse. LDACn stays high.
- cmd=4'h1, code=12'h800: frame 24'h180000, followed by LDACn low for 2 cycles after SYNCn rises; busy 104 cycles.
- Back-to-back with valid held high and codes 12'h000 then 12'hFFF: second frame 24'h3FFF00 is accepted one cycle after done; SYNCn high ≥4 cycles between frames.
- valid pulsed while busy, mid-SHIFT: ignored, with no change to the frame in progress and no extra done.
- RESET asserted during bit 10 of a frame: next cycle SYNCn=1, SCL=1, RSTn=0. RST_HOLD reruns the full 50 cycles. A subsequent 12'h123 frame shifts correctly as 24'h312300.

Source files
------------

// File: rtl/ad5681r_dac_spi.sv
// ============================================================================
// Module   : ad5681r_dac_spi
// Purpose  : 24-bit SPI frame driver for the AD5681R DAC with RSTn/LDACn control
// Revision : 1.0
// ============================================================================
`default_nettype none

module ad5681r_dac_spi #(
    parameter int CLK_DIV    = 2,
    parameter int RST_CYCLES = 50
) (
    input  logic        SYS_CLK,
    input  logic        RESET,
    input  logic [3:0]  cmd,
    input  logic [11:0] code,
    input  logic        valid,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        AD5681R_SYNCn,
    output logic        AD5681R_SCL,
    output logic        AD5681R_SDA,
    output logic        AD5681R_LDACn,
    output logic        AD5681R_RSTn
);

    localparam int CNT_MAX = (RST_CYCLES > CLK_DIV) ? RST_CYCLES : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

    localparam logic [2:0] ST_RST_HOLD = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_SETUP    = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_LDAC     = 3'd5;
    localparam logic [2:0] ST_GAP      = 3'd6;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [4:0]       bit_cnt, bit_cnt_n;
    logic [23:0]      shreg, shreg_n;
    logic             phase, phase_n;
    logic             is_ldac, is_ldac_n;
    logic             div_end;

    assign div_end = (cnt == DIV_LAST);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        phase_n   = phase;
        is_ldac_n = is_ldac;
        case (state)
            ST_RST_HOLD: begin
                if (cnt == RST_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (valid) begin
                    shreg_n   = {cmd, code, 8'h00};
                    is_ldac_n = (cmd == 4'b0001);
                    state_n   = ST_SETUP;
                    cnt_n     = '0;
                end
            end
            ST_SETUP: begin
                if (div_end) begin
                    state_n   = ST_SHIFT;
                    cnt_n     = '0;
                    phase_n   = 1'b0;
                    bit_cnt_n = 5'd23;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_end) begin
                    cnt_n = '0;
                    // Low phase ends at the SCL rise, which is where the next bit goes out.
                    if (!phase) begin
                        phase_n = 1'b1;
                        shreg_n = {shreg[22:0], 1'b0};
                    end else begin
                        phase_n = 1'b0;
                        if (bit_cnt == 5'd0) begin
                            state_n = ST_HOLD;
                        end else begin
                            bit_cnt_n = bit_cnt - 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (div_end) begin
                    cnt_n   = '0;
                    state_n = is_ldac ? ST_LDAC : ST_GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_LDAC: begin
                if (div_end) begin
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (div_end) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_RST_HOLD;
                cnt_n   = '0;
            end
        endcase
    end

    // Handshake flags track the next state; pins are decoded from the current
    // state, so the SPI pins trail the FSM by one cycle.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state         <= ST_RST_HOLD;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            phase         <= 1'b0;
            is_ldac       <= 1'b0;
            ready         <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            AD5681R_SYNCn <= 1'b1;
            AD5681R_SCL   <= 1'b1;
            AD5681R_SDA   <= 1'b0;
            AD5681R_LDACn <= 1'b1;
            AD5681R_RSTn  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            phase         <= phase_n;
            is_ldac       <= is_ldac_n;
            ready         <= (state_n == ST_IDLE);
            busy          <= (state_n != ST_IDLE);
            done          <= (state_n == ST_GAP) && (cnt_n == DIV_LAST);
            AD5681R_SYNCn <= !((state == ST_SETUP) || (state == ST_SHIFT));
            AD5681R_SCL   <= !((state == ST_SHIFT) && !phase);
            AD5681R_SDA   <= ((state == ST_SETUP) || (state == ST_SHIFT)) ? shreg[23] : 1'b0;
            AD5681R_LDACn <= (state != ST_LDAC);
            AD5681R_RSTn  <= (state_n != ST_RST_HOLD);
        end
    end

endmodule

`default_nettype wire
